// File: rtl/branch_predict_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_unit
//
// Fetch-side next-PC generator. It holds the fetch PC register and predicts
// every cycle from a direct-mapped branch target buffer (BTB). Each BTB entry
// has a 2-bit saturating direction counter. Branches resolved in execute have
// their actual target computed here. The unit flags mispredicts, redirects
// fetch, and trains the BTB.
//
// Optional feature: define BRANCH_STATS_EN to add two 32-bit event counters,
// stat_branches and stat_mispredicts.
//
// Parameters:
//   WordSize  width of PC, immediates, operands and targets
//   Entries   number of BTB entries (power of 2, >= 2)
//   ResetVec  PC loaded on reset
//
// Ports:
//   clk, rst             clock and asynchronous active-high reset
//   stall                hold the fetch PC (a mispredict overrides it)
//   pc                   current fetch PC (registered)
//   pred_taken           prediction for pc (BTB hit and counter MSB set)
//   pred_target          BTB target on a hit, otherwise pc+4
//   resolve_valid        a branch resolves this cycle
//   resolve_pc           PC of the resolving branch
//   addr_mode            0: resolve_pc+imm, 1: (imm+rs1d) with bit 0 cleared
//   branch_taken         actual direction of the branch
//   imm, rs1d            sign-extended immediate and rs1 data
//   resolve_pred_taken   direction predicted at fetch
//   resolve_pred_target  target predicted at fetch
//   branch_addr          computed target (combinational)
//   mispredict           redirect strobe (combinational)
//   stat_branches        [BRANCH_STATS_EN] resolved branch count
//   stat_mispredicts     [BRANCH_STATS_EN] mispredict count
// -----------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int                   WordSize = 32,
    parameter int                   Entries  = 16,
    parameter logic [WordSize-1:0]  ResetVec = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    output logic [WordSize-1:0] pc,
    output logic                pred_taken,
    output logic [WordSize-1:0] pred_target,
    input  logic                resolve_valid,
    input  logic [WordSize-1:0] resolve_pc,
    input  logic                addr_mode,
    input  logic                branch_taken,
    input  logic [WordSize-1:0] imm,
    input  logic [WordSize-1:0] rs1d,
    input  logic                resolve_pred_taken,
    input  logic [WordSize-1:0] resolve_pred_target,
    output logic [WordSize-1:0] branch_addr,
`ifdef BRANCH_STATS_EN
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts,
`endif
    output logic                mispredict
);

    localparam int IdxBits = $clog2(Entries);
    localparam int TagBits = WordSize - IdxBits - 2;
    localparam logic [WordSize-1:0] Four = WordSize'(4);

    // Per-entry valid bits and counters are gathered into packed vectors
    // so that the lookup logic can index them.
    logic [Entries-1:0]      valid_vec;
    logic [Entries-1:0][1:0] cnt_vec;

    // Tags and targets have no reset, because the valid bits qualify them.
    logic [TagBits-1:0]  tag_mem    [Entries];
    logic [WordSize-1:0] target_mem [Entries];

    logic [WordSize-1:0] pc_reg;
    logic [WordSize-1:0] pc_next;

    // ---------------------------------------------------------------- fetch
    logic [IdxBits-1:0] fetch_idx;
    logic [TagBits-1:0] fetch_tag;
    logic               fetch_hit;
    logic [WordSize-1:0] pc_plus4;

    assign fetch_idx = pc_reg[IdxBits+1:2];
    assign fetch_tag = pc_reg[WordSize-1:IdxBits+2];
    assign fetch_hit = valid_vec[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
    assign pc_plus4  = pc_reg + Four;

    assign pc          = pc_reg;
    assign pred_taken  = fetch_hit && cnt_vec[fetch_idx][1];
    assign pred_target = fetch_hit ? target_mem[fetch_idx] : pc_plus4;

    // -------------------------------------------------------------- resolve
    logic [WordSize-1:0] actual_npc;
    logic [IdxBits-1:0]  res_idx;
    logic [TagBits-1:0]  res_tag;
    logic                res_hit;

    // A register-relative target has bit 0 forced low, like JALR.
    assign branch_addr = addr_mode ? ((imm + rs1d) & ~WordSize'(1))
                                   : (resolve_pc + imm);
    assign actual_npc  = branch_taken ? branch_addr : (resolve_pc + Four);

    assign mispredict = resolve_valid &&
                        ((resolve_pred_taken != branch_taken) ||
                         (branch_taken && (resolve_pred_target != branch_addr)));

    assign res_idx = resolve_pc[IdxBits+1:2];
    assign res_tag = resolve_pc[WordSize-1:IdxBits+2];
    assign res_hit = valid_vec[res_idx] && (tag_mem[res_idx] == res_tag);

    // --------------------------------------------------------------- next pc
    always_comb begin
        pc_next = pc_plus4;
        if (mispredict) begin
            pc_next = actual_npc;
        end else if (stall) begin
            pc_next = pc_reg;
        end else if (pred_taken) begin
            pc_next = pred_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg <= ResetVec;
        end else begin
            pc_reg <= pc_next;
        end
    end

    // ------------------------------------------------------------- training
    function automatic logic [1:0] sat_update(input logic [1:0] c, input logic up);
        logic [1:0] r;
        r = c;
        if (up && (c != 2'b11)) begin
            r = c + 2'b01;
        end else if (!up && (c != 2'b00)) begin
            r = c - 2'b01;
        end
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < Entries; gi++) begin : g_entry
            logic       valid_reg;
            logic [1:0] cnt_reg;
            logic       sel;

            assign sel = resolve_valid && (res_idx == IdxBits'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    cnt_reg   <= 2'b01;
                end else if (sel) begin
                    if (res_hit) begin
                        cnt_reg <= sat_update(cnt_reg, branch_taken);
                    end else if (branch_taken) begin
                        // A taken miss allocates the entry, replacing any occupant.
                        valid_reg <= 1'b1;
                        cnt_reg   <= 2'b10;
                    end
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign cnt_vec[gi]   = cnt_reg;
        end
    endgenerate

    // A taken branch writes the target on both a hit and an allocation.
    // On a hit the tag write is a no-op, so one write path covers both cases.
    always_ff @(posedge clk) begin
        if (resolve_valid && branch_taken) begin
            tag_mem[res_idx]    <= res_tag;
            target_mem[res_idx] <= branch_addr;
        end
    end

`ifdef BRANCH_STATS_EN
    // ------------------------------------------------------------ statistics
    logic [31:0] branches_reg;
    logic [31:0] mispredicts_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branches_reg    <= '0;
            mispredicts_reg <= '0;
        end else begin
            if (resolve_valid) begin
                branches_reg <= branches_reg + 32'd1;
            end
            if (mispredict) begin
                mispredicts_reg <= mispredicts_reg + 32'd1;
            end
        end
    end

    assign stat_branches    = branches_reg;
    assign stat_mispredicts = mispredicts_reg;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_predict_unit
//
// Directed bench for branch_predict_unit using the default parameters
// (32-bit words, 16 BTB entries, reset vector 0). Each step drives the inputs
// just after a rising edge. Combinational outputs are checked before the next
// edge, and the registered pc is checked just after that edge.
// -----------------------------------------------------------------------------
module tb_branch_predict_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic        addr_mode;
    logic        branch_taken;
    logic [31:0] imm;
    logic [31:0] rs1d;
    logic        resolve_pred_taken;
    logic [31:0] resolve_pred_target;
    logic [31:0] branch_addr;
    logic        mispredict;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int total;
    int bad;

    branch_predict_unit #(
        .WordSize (32),
        .Entries  (16),
        .ResetVec (32'h0)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall               (stall),
        .pc                  (pc),
        .pred_taken          (pred_taken),
        .pred_target         (pred_target),
        .resolve_valid       (resolve_valid),
        .resolve_pc          (resolve_pc),
        .addr_mode           (addr_mode),
        .branch_taken        (branch_taken),
        .imm                 (imm),
        .rs1d                (rs1d),
        .resolve_pred_taken  (resolve_pred_taken),
        .resolve_pred_target (resolve_pred_target),
        .branch_addr         (branch_addr),
`ifdef BRANCH_STATS_EN
        .stat_branches       (stat_branches),
        .stat_mispredicts    (stat_mispredicts),
`endif
        .mispredict          (mispredict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] rpc, input logic mode, input logic tk,
                         input logic [31:0] im, input logic [31:0] r1,
                         input logic pt, input logic [31:0] ptg);
        resolve_valid       = 1'b1;
        resolve_pc          = rpc;
        addr_mode           = mode;
        branch_taken        = tk;
        imm                 = im;
        rs1d                = r1;
        resolve_pred_taken  = pt;
        resolve_pred_target = ptg;
    endtask

    task automatic idle();
        resolve_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        stall = 1'b0;
        resolve_valid = 1'b0;
        resolve_pc = '0;
        addr_mode = 1'b0;
        branch_taken = 1'b0;
        imm = '0;
        rs1d = '0;
        resolve_pred_taken = 1'b0;
        resolve_pred_target = '0;

        // Reset state
        #2;
        chk("rst_pc", pc, 32'h0);
        chk("rst_pred_taken", {31'b0, pred_taken}, 32'h0);
        chk("rst_pred_target", pred_target, 32'h4);
        chk("rst_mispredict", {31'b0, mispredict}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rel_pc", pc, 32'h0);

        // Sequential fetch with no predictions
        tick(); chk("seq_pc4", pc, 32'h4);
        chk("seq_pt4", {31'b0, pred_taken}, 32'h0);
        tick(); chk("seq_pc8", pc, 32'h8);
        tick(); chk("seq_pcC", pc, 32'hC);
        chk("seq_ptC", {31'b0, pred_taken}, 32'h0);

        // PC-relative taken branch, predicted not taken
        drive(32'h10, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 32'h0); #1;
        chk("pcrel_ba", branch_addr, 32'h30);
        chk("pcrel_mp", {31'b0, mispredict}, 32'h1);
        tick(); idle(); chk("pcrel_pc", pc, 32'h30);
        // Redirect fetch to 0x10 with a not-taken mispredict at 0x0C
        drive(32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0); #1;
        chk("redir_mp", {31'b0, mispredict}, 32'h1);
        tick(); idle(); #1;
        chk("hit_pc", pc, 32'h10);
        chk("hit_pt", {31'b0, pred_taken}, 32'h1);
        chk("hit_ptg", pred_target, 32'h30);
        tick(); chk("hit_follow", pc, 32'h30);

        // Register-relative target, correct and wrong predicted target
        drive(32'h200, 1'b1, 1'b1, 32'h4, 32'h1001, 1'b1, 32'h1004); #1;
        chk("reg_ba", branch_addr, 32'h1004);
        chk("reg_mp_ok", {31'b0, mispredict}, 32'h0);
        tick(); chk("reg_pc_ok", pc, 32'h34);
        drive(32'h200, 1'b1, 1'b1, 32'h4, 32'h1001, 1'b1, 32'h1000); #1;
        chk("reg_mp_bad", {31'b0, mispredict}, 32'h1);
        tick(); idle(); chk("reg_pc_bad", pc, 32'h1004);

        // Counter training on 0x10: currently 10, taken x2 -> 11, not-taken x2 -> 01
        drive(32'h10, 1'b0, 1'b1, 32'h20, 32'h0, 1'b1, 32'h30); #1;
        chk("tr_t1_mp", {31'b0, mispredict}, 32'h0);
        tick();
        drive(32'h10, 1'b0, 1'b1, 32'h20, 32'h0, 1'b1, 32'h30); #1;
        chk("tr_t2_mp", {31'b0, mispredict}, 32'h0);
        tick(); chk("tr_t2_pc", pc, 32'h100C);
        drive(32'h10, 1'b0, 1'b0, 32'h20, 32'h0, 1'b1, 32'h30); #1;
        chk("tr_n1_mp", {31'b0, mispredict}, 32'h1);
        tick(); chk("tr_n1_pc", pc, 32'h14);
        drive(32'h10, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h30); #1;
        chk("tr_n2_mp", {31'b0, mispredict}, 32'h0);
        tick(); chk("tr_n2_pc", pc, 32'h18);
        drive(32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        tick(); idle(); #1;
        chk("tr_fetch_pc", pc, 32'h10);
        chk("tr_fetch_pt", {31'b0, pred_taken}, 32'h0);
        chk("tr_fetch_ptg", pred_target, 32'h30);
        tick(); chk("tr_follow", pc, 32'h14);

        // Mispredict overrides stall; stall alone holds pc
        stall = 1'b1;
        drive(32'h40, 1'b0, 1'b1, 32'h40, 32'h0, 1'b0, 32'h0); #1;
        chk("stall_ba", branch_addr, 32'h80);
        chk("stall_mp", {31'b0, mispredict}, 32'h1);
        tick(); idle(); chk("stall_redir", pc, 32'h80);
        tick(); chk("stall_hold", pc, 32'h80);
        // Same-cycle fetch and training of the fetched entry while stalled
        drive(32'h80, 1'b0, 1'b1, 32'h20, 32'h0, 1'b1, 32'hA0); #1;
        chk("same_mp", {31'b0, mispredict}, 32'h0);
        chk("same_pt_pre", {31'b0, pred_taken}, 32'h0);
        tick(); idle(); #1;
        chk("same_pc", pc, 32'h80);
        chk("same_pt_post", {31'b0, pred_taken}, 32'h1);
        chk("same_ptg_post", pred_target, 32'hA0);
        stall = 1'b0;
        tick(); chk("same_follow", pc, 32'hA0);

        // Aliasing: 0x50 evicts 0x10 (both index 4)
        drive(32'h50, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0); #1;
        chk("alias_ba", branch_addr, 32'h60);
        tick(); idle(); chk("alias_pc", pc, 32'h60);
        drive(32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        tick(); idle(); #1;
        chk("alias_pc10", pc, 32'h10);
        chk("alias_pt10", {31'b0, pred_taken}, 32'h0);
        chk("alias_ptg10", pred_target, 32'h14);
        drive(32'h4C, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        tick(); idle(); #1;
        chk("alias_pc50", pc, 32'h50);
        chk("alias_pt50", {31'b0, pred_taken}, 32'h1);
        chk("alias_ptg50", pred_target, 32'h60);

        // Asynchronous reset mid-run, with a pending training that must be dropped
        #2;
        rst = 1'b1;
        drive(32'h10, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 32'h0);
        #1;
        chk("mrst_pc", pc, 32'h0);
        chk("mrst_pt", {31'b0, pred_taken}, 32'h0);
        chk("mrst_ptg", pred_target, 32'h4);
        tick();
        rst = 1'b0;
        idle(); #1;
        chk("mrst_hold", pc, 32'h0);
        drive(32'h4C, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        tick(); idle(); #1;
        chk("mrst_pc50", pc, 32'h50);
        chk("mrst_pt50", {31'b0, pred_taken}, 32'h0);
        chk("mrst_ptg50", pred_target, 32'h54);
        drive(32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        tick(); idle(); #1;
        chk("mrst_pc10", pc, 32'h10);
        chk("mrst_pt10", {31'b0, pred_taken}, 32'h0);
        chk("mrst_ptg10", pred_target, 32'h14);
`ifdef BRANCH_STATS_EN
        chk("stat_br", stat_branches, 32'd2);
        chk("stat_mp", stat_mispredicts, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
